// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the alu_mdu execute-stage unit.
//   - op_e      : 5-bit operation codes
//   - state_e   : multiply/divide sequencer states
//   - DIV0_*    : fixed results for divide-by-zero
//   - is_iter_op: true for ops that run on the iterative multiply/divide unit
// Optional feature macro: ALU_DIV_EN (div/divu built when defined).
package alu_pkg;

  typedef enum logic [4:0] {
    OpAnd   = 5'b00000,
    OpOr    = 5'b00001,
    OpAdd   = 5'b00010,
    OpAddu  = 5'b00011,
    OpSub   = 5'b00100,
    OpSubu  = 5'b00101,
    OpSlt   = 5'b00110,
    OpSltu  = 5'b00111,
    OpSll   = 5'b01000,
    OpSrl   = 5'b01001,
    OpSllv  = 5'b01010,
    OpSrlv  = 5'b01011,
    OpLui   = 5'b01100,
    OpSra   = 5'b01101,
    OpXor   = 5'b01110,
    OpNor   = 5'b01111,
    OpMult  = 5'b10000,
    OpMultu = 5'b10001,
    OpDiv   = 5'b10010,
    OpDivu  = 5'b10011,
    OpMfhi  = 5'b10100,
    OpMflo  = 5'b10101,
    OpMthi  = 5'b10110,
    OpMtlo  = 5'b10111
  } op_e;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StIter = 2'd1,
    StDone = 2'd2
  } state_e;

  // Divide by zero: every quotient bit set, HI returns the original dividend.
  localparam logic DIV0_QUO_BIT    = 1'b1;
  localparam logic DIV0_HI_DIVIDEND = 1'b1;

  function automatic logic is_iter_op(input logic [4:0] opcode);
`ifdef ALU_DIV_EN
    return (opcode == OpMult) || (opcode == OpMultu) || (opcode == OpDiv) || (opcode == OpDivu);
`else
    return (opcode == OpMult) || (opcode == OpMultu);
`endif
  endfunction

endpackage

// File: rtl/mdu_iter.sv
// mdu_iter: radix-2 iterative multiply / restoring divide, one bit per cycle.
// Ports:
//   clk, rst_n      : clock, synchronous active-low reset
//   i_start         : accept an operation (only honoured when idle)
//   i_signed, i_div : signed operands / divide instead of multiply
//   i_a, i_b        : operands (multiplier/dividend, multiplicand/divisor)
//   o_idle          : sequencer in IDLE
//   o_done          : high during the DONE cycle; o_hi/o_lo valid then
//   o_hi, o_lo      : sign-corrected HI/LO results
// Optional feature macro: ALU_DIV_EN builds the divider datapath.
module mdu_iter
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic             i_signed,
  input  logic             i_div,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_idle,
  output logic             o_done,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  state_e            r_state;
  logic [CntW-1:0]   r_cnt;
  logic [WIDTH-1:0]  r_hi;
  logic [WIDTH-1:0]  r_lo;
  logic [WIDTH-1:0]  r_b;
  logic              r_neg_lo;  // product / quotient must be negated
  logic              r_done;

  logic [WIDTH-1:0]   w_a_mag;
  logic [WIDTH-1:0]   w_b_mag;
  logic [WIDTH:0]     w_sum;
  logic [WIDTH-1:0]   w_hi_nxt;
  logic [WIDTH-1:0]   w_lo_nxt;
  logic [2*WIDTH-1:0] w_prod;

`ifdef ALU_DIV_EN
  logic              r_div;
  logic              r_neg_hi;  // remainder follows the dividend's sign
  logic              r_div0;
  logic [WIDTH-1:0]  r_dividend;
  logic [WIDTH:0]    w_shift;
  logic [WIDTH:0]    w_trial;
`else
  logic w_unused_div;
  assign w_unused_div = i_div;
`endif

  // Magnitudes are taken at accept; -MIN wraps to 2^(WIDTH-1), which is the correct magnitude.
  assign w_a_mag = (i_signed && i_a[WIDTH-1]) ? -i_a : i_a;
  assign w_b_mag = (i_signed && i_b[WIDTH-1]) ? -i_b : i_b;

  always_comb begin
    // Multiply step: conditional add of multiplicand into HI, then shift {carry,HI,LO} right.
    w_sum    = {1'b0, r_hi} + ({1'b0, r_b} & {(WIDTH + 1){r_lo[0]}});
    w_hi_nxt = w_sum[WIDTH:1];
    w_lo_nxt = {w_sum[0], r_lo[WIDTH-1:1]};
`ifdef ALU_DIV_EN
    // Restoring divide step: remainder in HI, quotient shifts into LO from the right.
    w_shift = {r_hi, r_lo[WIDTH-1]};
    w_trial = w_shift - {1'b0, r_b};
    if (r_div) begin
      w_hi_nxt = w_trial[WIDTH] ? w_shift[WIDTH-1:0] : w_trial[WIDTH-1:0];
      w_lo_nxt = {r_lo[WIDTH-2:0], ~w_trial[WIDTH]};
    end
`endif
  end

  assign w_prod = r_neg_lo ? -{r_hi, r_lo} : {r_hi, r_lo};

  always_comb begin
    o_hi = w_prod[2*WIDTH-1:WIDTH];
    o_lo = w_prod[WIDTH-1:0];
`ifdef ALU_DIV_EN
    if (r_div) begin
      if (r_div0) begin
        o_lo = {WIDTH{DIV0_QUO_BIT}};
        o_hi = DIV0_HI_DIVIDEND ? r_dividend : r_hi;
      end else begin
        o_lo = r_neg_lo ? -r_lo : r_lo;
        o_hi = r_neg_hi ? -r_hi : r_hi;
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= StIdle;
      r_cnt      <= '0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_b        <= '0;
      r_neg_lo   <= 1'b0;
      r_done     <= 1'b0;
`ifdef ALU_DIV_EN
      r_div      <= 1'b0;
      r_neg_hi   <= 1'b0;
      r_div0     <= 1'b0;
      r_dividend <= '0;
`endif
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (i_start) begin
            r_state  <= StIter;
            r_cnt    <= '0;
            r_hi     <= '0;
            r_lo     <= w_a_mag;
            r_b      <= w_b_mag;
            r_neg_lo <= i_signed && (i_a[WIDTH-1] ^ i_b[WIDTH-1]);
`ifdef ALU_DIV_EN
            r_div      <= i_div;
            r_neg_hi   <= i_signed && i_a[WIDTH-1];
            r_div0     <= (i_b == '0);
            r_dividend <= i_a;
`endif
          end
        end
        StIter: begin
          r_hi  <= w_hi_nxt;
          r_lo  <= w_lo_nxt;
          r_cnt <= r_cnt + CntW'(1);
          if (r_cnt == LastCnt) begin
            r_state <= StDone;
            r_done  <= 1'b1;
          end
        end
        StDone: begin
          r_state <= StIdle;
        end
        default: begin
          r_state <= StIdle;
        end
      endcase
    end
  end

  assign o_idle = (r_state == StIdle);
  assign o_done = r_done;

endmodule

// File: rtl/alu_mdu.sv
// alu_mdu: registered MIPS execute-stage ALU with iterative multiply/divide and HI/LO.
// Ports:
//   clk, rst_n          : clock, synchronous active-low reset
//   in_valid / in_ready : request handshake; ready only while the multiply/divide unit is idle
//   op, src_a, src_b    : opcode (alu_pkg::op_e) and operands
//   shamt               : immediate shift amount
//   out_valid           : one-cycle completion pulse
//   res, zero           : result (held between pulses) and res == 0
//   overflow, illegal   : signed add/sub overflow, undefined or compiled-out op
// Optional feature macro: ALU_DIV_EN (div/divu are illegal single-cycle ops when undefined).
module alu_mdu
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [4:0]         op,
  input  logic [WIDTH-1:0]   src_a,
  input  logic [WIDTH-1:0]   src_b,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               out_valid,
  output logic [WIDTH-1:0]   res,
  output logic               zero,
  output logic               overflow,
  output logic               illegal
);

  localparam int unsigned LuiSh = WIDTH - 16;

  // Request stage: single-cycle ops are captured here and resolved on the following edge.
  logic               r_s1_valid;
  logic [4:0]         r_s1_op;
  logic [WIDTH-1:0]   r_s1_a;
  logic [WIDTH-1:0]   r_s1_b;
  logic [SHAMT_W-1:0] r_s1_shamt;

  logic               r_out_valid;
  logic [WIDTH-1:0]   r_res;
  logic               r_zero;
  logic               r_overflow;
  logic               r_illegal;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;

  logic               w_accept;
  logic               w_iter;
  logic               w_mdu_idle;
  logic               w_mdu_done;
  logic [WIDTH-1:0]   w_mdu_hi;
  logic [WIDTH-1:0]   w_mdu_lo;
  logic [WIDTH-1:0]   w_add;
  logic [WIDTH-1:0]   w_sub;
  logic [WIDTH-1:0]   w_res;
  logic               w_ovf;
  logic               w_illegal;
  logic               w_wr_hi;
  logic               w_wr_lo;

  assign in_ready = w_mdu_idle;
  assign w_accept = in_valid && in_ready;
  assign w_iter   = is_iter_op(op);

  mdu_iter #(
    .WIDTH (WIDTH)
  ) u_mdu (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_start  (w_accept && w_iter),
    .i_signed ((op == OpMult) || (op == OpDiv)),
    .i_div    ((op == OpDiv) || (op == OpDivu)),
    .i_a      (src_a),
    .i_b      (src_b),
    .o_idle   (w_mdu_idle),
    .o_done   (w_mdu_done),
    .o_hi     (w_mdu_hi),
    .o_lo     (w_mdu_lo)
  );

  assign w_add = r_s1_a + r_s1_b;
  assign w_sub = r_s1_a - r_s1_b;

  always_comb begin
    w_res     = '0;
    w_ovf     = 1'b0;
    w_illegal = 1'b0;
    w_wr_hi   = 1'b0;
    w_wr_lo   = 1'b0;
    case (r_s1_op)
      OpAnd:  w_res = r_s1_a & r_s1_b;
      OpOr:   w_res = r_s1_a | r_s1_b;
      OpXor:  w_res = r_s1_a ^ r_s1_b;
      OpNor:  w_res = ~(r_s1_a | r_s1_b);
      OpAdd: begin
        w_res = w_add;
        w_ovf = (r_s1_a[WIDTH-1] == r_s1_b[WIDTH-1]) && (w_add[WIDTH-1] != r_s1_a[WIDTH-1]);
      end
      OpAddu: w_res = w_add;
      OpSub: begin
        w_res = w_sub;
        w_ovf = (r_s1_a[WIDTH-1] != r_s1_b[WIDTH-1]) && (w_sub[WIDTH-1] != r_s1_a[WIDTH-1]);
      end
      OpSubu: w_res = w_sub;
      OpSlt:  w_res = WIDTH'($signed(r_s1_a) < $signed(r_s1_b));
      OpSltu: w_res = WIDTH'(r_s1_a < r_s1_b);
      OpSll:  w_res = r_s1_b << r_s1_shamt;
      OpSrl:  w_res = r_s1_b >> r_s1_shamt;
      OpSra:  w_res = $unsigned($signed(r_s1_b) >>> r_s1_shamt);
      OpSllv: w_res = r_s1_b << r_s1_a[SHAMT_W-1:0];
      OpSrlv: w_res = r_s1_b >> r_s1_a[SHAMT_W-1:0];
      OpLui:  w_res = r_s1_b << LuiSh;
      OpMfhi: w_res = r_hi;
      OpMflo: w_res = r_lo;
      OpMthi: begin
        w_res   = r_s1_a;
        w_wr_hi = 1'b1;
      end
      OpMtlo: begin
        w_res   = r_s1_a;
        w_wr_lo = 1'b1;
      end
      // Also catches div/divu when the divider is not built.
      default: w_illegal = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_op    <= '0;
      r_s1_a     <= '0;
      r_s1_b     <= '0;
      r_s1_shamt <= '0;
    end else begin
      r_s1_valid <= w_accept && !w_iter;
      if (w_accept) begin
        r_s1_op    <= op;
        r_s1_a     <= src_a;
        r_s1_b     <= src_b;
        r_s1_shamt <= shamt;
      end
    end
  end

  // A single-cycle result and an MDU completion never coincide: no accept is possible while busy.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_res       <= '0;
      r_zero      <= 1'b0;
      r_overflow  <= 1'b0;
      r_illegal   <= 1'b0;
      r_hi        <= '0;
      r_lo        <= '0;
    end else begin
      r_out_valid <= 1'b0;
      if (r_s1_valid) begin
        r_out_valid <= 1'b1;
        r_res       <= w_res;
        r_zero      <= (w_res == '0);
        r_overflow  <= w_ovf;
        r_illegal   <= w_illegal;
        if (w_wr_hi) r_hi <= r_s1_a;
        if (w_wr_lo) r_lo <= r_s1_a;
      end else if (w_mdu_done) begin
        r_out_valid <= 1'b1;
        r_res       <= '0;
        r_zero      <= 1'b1;
        r_overflow  <= 1'b0;
        r_illegal   <= 1'b0;
        r_hi        <= w_mdu_hi;
        r_lo        <= w_mdu_lo;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign res       = r_res;
  assign zero      = r_zero;
  assign overflow  = r_overflow;
  assign illegal   = r_illegal;

endmodule

// File: tb/tb_alu_mdu.sv
// tb_alu_mdu: directed self-checking bench for alu_mdu (WIDTH = 32).
// Handles both builds; divide expectations follow ALU_DIV_EN.
module tb_alu_mdu;
  import alu_pkg::*;

  localparam int unsigned W = 32;

  typedef struct {
    logic [4:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [4:0]   sh;
    logic [W-1:0] res;
    logic         ovf;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [4:0]   op = 5'd0;
  logic [W-1:0] src_a = '0;
  logic [W-1:0] src_b = '0;
  logic [4:0]   shamt = 5'd0;
  logic         out_valid;
  logic [W-1:0] res;
  logic         zero;
  logic         overflow;
  logic         illegal;

  int n_checks = 0;
  int n_fail = 0;

  alu_mdu #(
    .WIDTH   (W),
    .SHAMT_W (5)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .src_a     (src_a),
    .src_b     (src_b),
    .shamt     (shamt),
    .out_valid (out_valid),
    .res       (res),
    .zero      (zero),
    .overflow  (overflow),
    .illegal   (illegal)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request for exactly one edge.
  task automatic issue(input logic [4:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [4:0] sh);
    op = o; src_a = a; src_b = b; shamt = sh; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  // Single-cycle op: outputs are checked right after this returns.
  task automatic run_op(input logic [4:0] o, input logic [W-1:0] a);
    issue(o, a, '0, 5'd0);
    tick();
  endtask

  // Called just after the accept edge; counts cycles to out_valid, bounded.
  task automatic wait_done(output int lat, output bit busy_ok);
    lat = 0;
    busy_ok = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (out_valid === 1'b1) begin
        lat = c;
        break;
      end
      if (in_ready !== 1'b0) busy_ok = 1'b0;
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    repeat (3) tick();
    n_checks++;
    if ({in_ready, out_valid, zero, overflow, illegal} !== 5'b10000) begin
      n_fail++;
      $display("FAIL reset_flags: got rdy/ov/z/ovf/ill=%b want 10000",
               {in_ready, out_valid, zero, overflow, illegal});
    end
    n_checks++;
    if (res !== '0) begin
      n_fail++;
      $display("FAIL reset_res: got %h want 0", res);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single_stream();
    vec_t v[18];
    vec_t e;
    v[0]  = '{5'b00010, 32'h7FFFFFFF, 32'h00000001, 5'd0,  32'h80000000, 1'b1}; // add
    v[1]  = '{5'b00011, 32'h7FFFFFFF, 32'h00000001, 5'd0,  32'h80000000, 1'b0}; // addu
    v[2]  = '{5'b00100, 32'h80000000, 32'h00000001, 5'd0,  32'h7FFFFFFF, 1'b1}; // sub
    v[3]  = '{5'b00101, 32'h00000000, 32'h00000001, 5'd0,  32'hFFFFFFFF, 1'b0}; // subu
    v[4]  = '{5'b00000, 32'hF0F0F0F0, 32'hFF00FF00, 5'd0,  32'hF000F000, 1'b0}; // and
    v[5]  = '{5'b00001, 32'hF0F0F0F0, 32'h0F0F0000, 5'd0,  32'hFFFFF0F0, 1'b0}; // or
    v[6]  = '{5'b01110, 32'hFFFF0000, 32'hFF00FF00, 5'd0,  32'h00FFFF00, 1'b0}; // xor
    v[7]  = '{5'b01111, 32'h00000000, 32'h0000FFFF, 5'd0,  32'hFFFF0000, 1'b0}; // nor
    v[8]  = '{5'b00110, 32'hFFFFFFFF, 32'h00000001, 5'd0,  32'h00000001, 1'b0}; // slt
    v[9]  = '{5'b00111, 32'hFFFFFFFF, 32'h00000001, 5'd0,  32'h00000000, 1'b0}; // sltu
    v[10] = '{5'b01000, 32'h00000000, 32'h00000001, 5'd31, 32'h80000000, 1'b0}; // sll
    v[11] = '{5'b01001, 32'h00000000, 32'h80000000, 5'd31, 32'h00000001, 1'b0}; // srl
    v[12] = '{5'b01010, 32'd36,       32'h00000001, 5'd0,  32'h00000010, 1'b0}; // sllv
    v[13] = '{5'b01011, 32'd36,       32'h80000000, 5'd0,  32'h08000000, 1'b0}; // srlv
    v[14] = '{5'b01101, 32'h00000000, 32'h80000000, 5'd4,  32'hF8000000, 1'b0}; // sra
    v[15] = '{5'b01100, 32'h00000000, 32'h0001ABCD, 5'd0,  32'hABCD0000, 1'b0}; // lui
    v[16] = '{5'b00100, 32'h00000005, 32'h00000005, 5'd0,  32'h00000000, 1'b0}; // sub -> 0
    v[17] = '{5'b11111, 32'h00000001, 32'h00000001, 5'd0,  32'h00000000, 1'b0}; // undefined
    // Back-to-back: a new request every edge while the previous result is checked.
    for (int i = 0; i <= 18; i++) begin
      if (i < 18) begin
        op = v[i].op; src_a = v[i].a; src_b = v[i].b; shamt = v[i].sh; in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      tick();
      n_checks++;
      if (i == 0) begin
        if (out_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL single_latency: out_valid got %b want 0 at accept edge", out_valid);
        end
      end else begin
        e = v[i-1];
        if ({out_valid, res, overflow, zero, illegal} !==
            {1'b1, e.res, e.ovf, (e.res == '0), (e.op == 5'b11111)}) begin
          n_fail++;
          $display("FAIL single_vec%0d op=%b: got ov=%b res=%h ovf=%b z=%b ill=%b want 1 %h %b %b %b",
                   i - 1, e.op, out_valid, res, overflow, zero, illegal,
                   e.res, e.ovf, (e.res == '0), (e.op == 5'b11111));
        end
      end
    end
    tick();
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL single_pulse: out_valid got %b want 0", out_valid);
    end
  endtask

  task automatic test_mult();
    int lat;
    bit busy_ok;
    issue(OpMult, 32'hFFFFFFFD, 32'd5, 5'd0);
    // A request held while busy must be ignored.
    op = OpMthi; src_a = 32'h12345678; in_valid = 1'b1;
    wait_done(lat, busy_ok);
    n_checks++;
    if (lat != 33) begin
      n_fail++;
      $display("FAIL mult_latency: got %0d cycles want 33", lat);
    end
    n_checks++;
    if (!busy_ok) begin
      n_fail++;
      $display("FAIL mult_busy: in_ready got 1 while busy, want 0");
    end
    n_checks++;
    if ({in_ready, res, zero, illegal} !== {1'b1, 32'h0, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL mult_done: got rdy=%b res=%h z=%b ill=%b want 1 0 1 0",
               in_ready, res, zero, illegal);
    end
    tick();
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL mult_pulse: out_valid got %b want 0", out_valid);
    end
    run_op(OpMflo, '0);
    n_checks++;
    if ({out_valid, res} !== {1'b1, 32'hFFFFFFF1}) begin
      n_fail++;
      $display("FAIL mult_lo: got ov=%b res=%h want 1 fffffff1", out_valid, res);
    end
    run_op(OpMfhi, '0);
    n_checks++;
    if (res !== 32'hFFFFFFFF) begin
      n_fail++;
      $display("FAIL mult_hi: got %h want ffffffff", res);
    end
    issue(OpMultu, 32'hFFFFFFFF, 32'd2, 5'd0);
    wait_done(lat, busy_ok);
    n_checks++;
    if (lat != 33) begin
      n_fail++;
      $display("FAIL multu_latency: got %0d cycles want 33", lat);
    end
    run_op(OpMfhi, '0);
    n_checks++;
    if (res !== 32'h00000001) begin
      n_fail++;
      $display("FAIL multu_hi: got %h want 00000001", res);
    end
    run_op(OpMflo, '0);
    n_checks++;
    if (res !== 32'hFFFFFFFE) begin
      n_fail++;
      $display("FAIL multu_lo: got %h want fffffffe", res);
    end
  endtask

`ifdef ALU_DIV_EN
  task automatic check_div(input logic [4:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] exp_lo, input logic [W-1:0] exp_hi);
    int lat;
    bit busy_ok;
    issue(o, a, b, 5'd0);
    wait_done(lat, busy_ok);
    n_checks++;
    if (lat != 33 || !busy_ok) begin
      n_fail++;
      $display("FAIL div_latency a=%h b=%h: got %0d cycles busy_ok=%b want 33 1", a, b, lat, busy_ok);
    end
    run_op(OpMflo, '0);
    n_checks++;
    if (res !== exp_lo) begin
      n_fail++;
      $display("FAIL div_lo a=%h b=%h: got %h want %h", a, b, res, exp_lo);
    end
    run_op(OpMfhi, '0);
    n_checks++;
    if (res !== exp_hi) begin
      n_fail++;
      $display("FAIL div_hi a=%h b=%h: got %h want %h", a, b, res, exp_hi);
    end
  endtask
`endif

  task automatic test_div();
`ifdef ALU_DIV_EN
    check_div(OpDiv,  32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 32'hFFFFFFFF);
    check_div(OpDivu, 32'd7,        32'd0,        32'hFFFFFFFF, 32'h00000007);
    check_div(OpDiv,  32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h00000000);
    check_div(OpDiv,  32'hFFFFFFF9, 32'd0,        32'hFFFFFFFF, 32'hFFFFFFF9);
`else
    run_op(OpMthi, 32'hA5A5A5A5);
    run_op(OpMtlo, 32'h5A5A5A5A);
    n_checks++;
    if (res !== 32'h5A5A5A5A) begin
      n_fail++;
      $display("FAIL mtlo_res: got %h want 5a5a5a5a", res);
    end
    issue(OpDiv, 32'hFFFFFFF9, 32'd2, 5'd0);
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL nodiv_ready: got %b want 1", in_ready);
    end
    tick();
    n_checks++;
    if ({out_valid, illegal, zero, res} !== {1'b1, 1'b1, 1'b1, 32'h0}) begin
      n_fail++;
      $display("FAIL nodiv_result: got ov=%b ill=%b z=%b res=%h want 1 1 1 0",
               out_valid, illegal, zero, res);
    end
    run_op(OpMfhi, '0);
    n_checks++;
    if (res !== 32'hA5A5A5A5) begin
      n_fail++;
      $display("FAIL nodiv_hi: got %h want a5a5a5a5", res);
    end
    run_op(OpMflo, '0);
    n_checks++;
    if (res !== 32'h5A5A5A5A) begin
      n_fail++;
      $display("FAIL nodiv_lo: got %h want 5a5a5a5a", res);
    end
`endif
  endtask

  task automatic test_illegal_keeps_hilo();
    run_op(OpMthi, 32'h0BADF00D);
    run_op(5'b11111, 32'h00000001);
    n_checks++;
    if ({out_valid, illegal, res} !== {1'b1, 1'b1, 32'h0}) begin
      n_fail++;
      $display("FAIL illegal_op: got ov=%b ill=%b res=%h want 1 1 0", out_valid, illegal, res);
    end
    run_op(OpMfhi, '0);
    n_checks++;
    if ({illegal, res} !== {1'b0, 32'h0BADF00D}) begin
      n_fail++;
      $display("FAIL illegal_hi: got ill=%b hi=%h want 0 0badf00d", illegal, res);
    end
  endtask

  task automatic test_reset_mid();
    bit seen;
    run_op(OpMtlo, 32'h00000055);
    issue(OpMult, 32'd3, 32'd5, 5'd0);
    repeat (10) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    n_checks++;
    if ({in_ready, out_valid, res} !== {1'b1, 1'b0, 32'h0}) begin
      n_fail++;
      $display("FAIL rst_mid_state: got rdy=%b ov=%b res=%h want 1 0 0", in_ready, out_valid, res);
    end
    seen = 1'b0;
    repeat (40) begin
      tick();
      if (out_valid !== 1'b0) seen = 1'b1;
    end
    n_checks++;
    if (seen) begin
      n_fail++;
      $display("FAIL rst_mid_no_valid: got out_valid pulse want none");
    end
    run_op(OpMfhi, '0);
    n_checks++;
    if ({out_valid, res} !== {1'b1, 32'h0}) begin
      n_fail++;
      $display("FAIL rst_mid_hi: got ov=%b hi=%h want 1 0", out_valid, res);
    end
    run_op(OpMflo, '0);
    n_checks++;
    if (res !== 32'h0) begin
      n_fail++;
      $display("FAIL rst_mid_lo: got %h want 0", res);
    end
  endtask

  initial begin
    test_reset();
    test_single_stream();
    test_mult();
    test_div();
    test_illegal_keeps_hilo();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_mdu.md
# alu_mdu

Parametrised registered ALU for the MIPS datapath, extended with an iterative multiply/divide unit and architectural HI/LO registers. Single-cycle ops return a registered result one clock after acceptance. mult/multu/div/divu run for WIDTH iterations behind a valid/ready handshake, while the execute stage holds off. Sits in the execute stage in place of the fixed 32-bit ALU.

## Interface
Parameters:
- WIDTH, 32: datapath width; must be ≥16 and a power of two.
- SHAMT_W, $clog2(WIDTH): shift-amount width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  operation request.
- in_ready  out  1  unit can accept; high only in IDLE.
- op  in  5  operation code (see Operation).
- src_a  in  WIDTH  operand A.
- src_b  in  WIDTH  operand B.
- shamt  in  SHAMT_W  immediate shift amount.
- out_valid  out  1  one-cycle pulse: result/completion.
- res  out  WIDTH  result; held until next out_valid.
- zero  out  1  res == 0, registered with res.
- overflow  out  1  signed overflow on add/sub; 0 otherwise.
- illegal  out  1  op undefined or compiled out.

## Operation
- Accept on in_valid && in_ready.
- Single-cycle ops:
  - 00000 and, 00001 or, 00010 add, 00011 addu, 00100 sub, 00101 subu.
  - 00110 slt, 00111 sltu.
  - 01000 sll, 01001 srl, use shamt.
  - 01010 sllv, 01011 srlv, use src_a[SHAMT_W-1:0].
  - 01100 lui = {src_b[15:0], zeros}.
  - 01101 sra.
  - 01110 xor, 01111 nor.
  - 10100 mfhi, 10101 mflo.
  - 10110 mthi, 10111 mtlo: write src_a; res = src_a.
- Iterative ops: 10000 mult, 10001 multu, 10010 div, 10011 divu. res = 0 at completion; HI/LO written on the completion edge.
- Signed multiply/divide: operands converted to magnitudes at accept, signs fixed at completion.
- Division semantics:
  - Quotient truncates toward zero; remainder takes the dividend's sign.
  - Most-negative / −1: LO = most-negative, HI = 0.
  - Divide by zero: LO = all ones, HI = dividend (src_a). Latency unchanged.
- Overflow: add/sub only, set when operand signs imply a sign flip of the result. addu/subu never flag.
- Undefined op: res = 0, illegal = 1, HI/LO unchanged, single-cycle latency.
- State machine:
  - IDLE → ITER on accept of an iterative op.
  - ITER counts WIDTH iterations, then → DONE.
  - DONE writes HI/LO, pulses out_valid, → IDLE.
- Reset values: all outputs 0 except in_ready = 1. HI = LO = 0, state IDLE, counter 0.

## Timing
- Single-cycle op accepted at edge N: res/zero/overflow/illegal valid and out_valid = 1 after edge N+1. Back-to-back accepts allowed every cycle.
- Iterative op accepted at edge N:
  - in_ready = 0 after edge N through the DONE cycle.
  - out_valid high for one cycle after edge N+WIDTH+1.
  - in_ready high again in that same cycle.
- mfhi/mflo cannot be accepted while busy; the first mfhi after completion sees the new HI.
- Reset mid-operation: iteration aborted, no out_valid, HI/LO cleared, in_ready = 1 after the reset edge.
- in_valid while in_ready = 0 is ignored; inputs need not be held.

## Configuration
- ALU_DIV_EN defined: div/divu implemented as above.
- ALU_DIV_EN undefined: no divider logic is built. div/divu are treated as undefined ops: single-cycle, illegal = 1, res = 0, HI/LO unchanged. mult/multu are unaffected.

## Structure
- Package alu_pkg holds:
  - the op code localparams/enum;
  - the state enum (IDLE, ITER, DONE);
  - divide-by-zero result constants.
- Sub-module mdu_iter: radix-2 shift-add multiplier / restoring divider with start, signed, div and done signals. Its divider datapath is wrapped in ALU_DIV_EN.
- Top level holds the combinational ALU, output registers, HI/LO and the handshake.

## Test plan
- add 0x7FFFFFFF + 0x00000001 → res 0x80000000, overflow 1, out_valid one cycle after accept. addu, same operands → overflow 0.
- sra 0x80000000, shamt 4 → 0xF8000000. srlv src_b 0x80000000, src_a 36 → 0x08000000 (shift 4).
- mult −3 × 5 → HI 0xFFFFFFFF, LO 0xFFFFFFF1. out_valid exactly 33 cycles after accept; in_ready 0 throughout. mflo next → 0xFFFFFFF1.
- div −7 / 2 → LO 0xFFFFFFFD, HI 0xFFFFFFFF. divu 7 / 0 → LO 0xFFFFFFFF, HI 0x00000007.
- rst_n low 10 cycles into a mult → no out_valid; in_ready 1, HI/LO 0, res 0 after the reset edge.
- Build without ALU_DIV_EN: div → illegal 1, res 0, out_valid after 1 cycle, HI/LO unchanged. Op 11111 → illegal 1 in both builds.
